// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit processor and its instruction sequencer:
// opcode encodings, bus word width and the sequencer state encoding.
package proc_pkg;

  localparam int WORD_W = 9;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAITRDY = 3'd1,
    S_ISSUE   = 3'd2,
    S_IMM     = 3'd3,
    S_WAITLO  = 3'd4,
    S_WAITHI  = 3'd5,
    S_FINISH  = 3'd6
  } seq_state_t;

  function automatic logic [2:0] opcode_of(input logic [WORD_W-1:0] word);
    return word[WORD_W-1:WORD_W-3];
  endfunction

endpackage

// File: rtl/prog_buffer.sv
// Program buffer: register array with synchronous write and two combinational
// read ports (current instruction and the word after it). Contents are not reset.
module prog_buffer
  import proc_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/proc_sequencer.sv
// Instruction sequencer: replays a loaded program into the processor over the
// DIN/Run/Done handshake, supplying mvi immediates and timing out a stuck Done.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = WORD_W,
  parameter int TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [DATA_W-1:0] LoadData,
  input  logic              Start,
  input  logic [ADDR_W:0]   Length,
  input  logic              ProcDone,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  output logic [ADDR_W-1:0] Pc,
  output logic              Busy,
  output logic              Finished,
  output logic              Error,
  output logic [2:0]        StateDbg
);

  // Handshake: Run is a single-cycle strobe issued only while ProcDone is high;
  // the processor acknowledges by dropping ProcDone, then raising it when the
  // instruction completes. An mvi immediate follows on DIN the cycle after Run.

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W:0]   pc_q, pc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              err_q, err_d;
  logic              mvi_q, mvi_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              run_d;

  logic [ADDR_W-1:0] addr_cur, addr_nxt;
  logic [DATA_W-1:0] word_cur, word_nxt;
  logic [ADDR_W:0]   pc_step;
  logic              busy_c;

  assign addr_cur = pc_q[ADDR_W-1:0];
  assign addr_nxt = addr_cur + ADDR_W'(1);
  assign busy_c   = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign pc_step  = pc_q + {{(ADDR_W-1){1'b0}}, mvi_q, ~mvi_q};

  prog_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk_i     (Clock),
    .we_i      (LoadEn && !busy_c),
    .waddr_i   (LoadAddr),
    .wdata_i   (LoadData),
    .raddr_a_i (addr_cur),
    .rdata_a_o (word_cur),
    .raddr_b_i (addr_nxt),
    .rdata_b_o (word_nxt)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
      mvi_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      din_q   <= din_d;
      err_q   <= err_d;
      mvi_q   <= mvi_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    din_d   = din_q;
    err_d   = err_q;
    mvi_d   = mvi_q;
    tcnt_d  = tcnt_q;
    run_d   = 1'b0;

    case (state_q)
      S_IDLE, S_FINISH: begin
        if (Start) begin
          len_d   = Length;
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = (Length == '0) ? S_FINISH : S_WAITRDY;
        end
      end
      S_WAITRDY: begin
        din_d = word_cur;
        if (ProcDone) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        din_d   = word_cur;
        run_d   = 1'b1;
        mvi_d   = (opcode_of(word_cur) == OP_MVI);
        tcnt_d  = '0;
        state_d = (opcode_of(word_cur) == OP_MVI) ? S_IMM : S_WAITLO;
      end
      S_IMM: begin
        // Address wraps modulo depth, so a trailing mvi reads word 0 at the top.
        din_d   = word_nxt;
        tcnt_d  = '0;
        state_d = S_WAITLO;
      end
      S_WAITLO: begin
        if (!ProcDone) begin
          tcnt_d  = '0;
          state_d = S_WAITHI;
        end else if (tcnt_q == TLAST) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_WAITHI: begin
        if (ProcDone) begin
          // Done is already high here, so the next instruction issues directly.
          pc_d    = pc_step;
          state_d = (pc_step >= len_q) ? S_FINISH : S_ISSUE;
        end else if (tcnt_q == TLAST) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign DIN      = din_d;
  assign Run      = run_d;
  assign Pc       = pc_q[ADDR_W-1:0];
  assign Busy     = busy_c;
  assign Finished = (state_q == S_FINISH);
  assign Error    = err_q;
  assign StateDbg = state_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer with a small behavioural processor model
// that answers Run by dropping Done one cycle after capture for done_delay cycles.
module tb_proc_sequencer;
  import proc_pkg::*;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 9;
  localparam int TIMEOUT = 15;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              LoadEn;
  logic [ADDR_W-1:0] LoadAddr;
  logic [DATA_W-1:0] LoadData;
  logic              Start;
  logic [ADDR_W:0]   Length;
  logic              ProcDone;
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic [ADDR_W-1:0] Pc;
  logic              Busy;
  logic              Finished;
  logic              Error;
  logic [2:0]        StateDbg;

  int vectors     = 0;
  int miscompares = 0;

  // Processor model state; written only by the model process.
  logic [DATA_W-1:0] regs [8] = '{default: '0};
  logic              model_done = 1'b1;
  logic              drop_next  = 1'b0;
  logic              pend_imm   = 1'b0;
  logic              prev_run   = 1'b0;
  logic              run_bad    = 1'b0;
  logic [2:0]        imm_rx     = 3'd0;
  int                cnt        = 0;
  int                run_cnt    = 0;

  // Model controls; written only by the test tasks.
  logic stuck      = 1'b0;
  logic hold_low   = 1'b0;
  int   done_delay = 3;

  assign ProcDone = model_done && !hold_low;

  proc_sequencer #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .LoadEn   (LoadEn),
    .LoadAddr (LoadAddr),
    .LoadData (LoadData),
    .Start    (Start),
    .Length   (Length),
    .ProcDone (ProcDone),
    .DIN      (DIN),
    .Run      (Run),
    .Pc       (Pc),
    .Busy     (Busy),
    .Finished (Finished),
    .Error    (Error),
    .StateDbg (StateDbg)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    logic [DATA_W-1:0] w;
    if (pend_imm) begin
      regs[imm_rx] = DIN;
      pend_imm = 1'b0;
    end
    if (drop_next) begin
      drop_next = 1'b0;
      if (!stuck) begin
        model_done = 1'b0;
        cnt = done_delay;
      end
    end else if (!model_done) begin
      cnt--;
      if (cnt == 0) model_done = 1'b1;
    end
    if (Run && (prev_run || !(model_done && !hold_low))) run_bad = 1'b1;
    prev_run = Run;
    if (Run) begin
      run_cnt++;
      w = DIN;
      case (w[8:6])
        OP_MV:  regs[w[5:3]] = regs[w[2:0]];
        OP_MVI: begin pend_imm = 1'b1; imm_rx = w[5:3]; end
        OP_ADD: regs[w[5:3]] = regs[w[5:3]] + regs[w[2:0]];
        OP_SUB: regs[w[5:3]] = regs[w[5:3]] - regs[w[2:0]];
        default: ;
      endcase
      drop_next = 1'b1;
    end
  end

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    @(posedge Clock); #1;
    LoadEn = 1'b0;
  endtask

  task automatic do_start(input logic [ADDR_W:0] len);
    Length = len; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  task automatic wait_run(input string name);
    logic found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clock); #1;
      if (Run) begin found = 1'b1; break; end
    end
    vectors++;
    if (found !== 1'b1) begin miscompares++; $display("FAIL %s_run_wait: Run not seen within 40 cycles", name); end
  endtask

  task automatic wait_finished(input string name);
    logic found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge Clock); #1;
      if (Finished) begin found = 1'b1; break; end
    end
    vectors++;
    if (found !== 1'b1) begin miscompares++; $display("FAIL %s_finish_wait: Finished not seen within 60 cycles", name); end
  endtask

  task automatic test_reset;
    Reset = 1'b1; LoadEn = 1'b0; LoadAddr = '0; LoadData = '0; Start = 1'b0; Length = '0;
    repeat (2) @(posedge Clock);
    #1;
    vectors++; if (DIN !== 9'd0) begin miscompares++; $display("FAIL reset_din: got %0h want 0", DIN); end
    vectors++; if (Run !== 1'b0) begin miscompares++; $display("FAIL reset_run: got %b want 0", Run); end
    vectors++; if (Pc !== 5'd0) begin miscompares++; $display("FAIL reset_pc: got %0d want 0", Pc); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", Busy); end
    vectors++; if (Finished !== 1'b0) begin miscompares++; $display("FAIL reset_finished: got %b want 0", Finished); end
    vectors++; if (Error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b want 0", Error); end
    vectors++; if (StateDbg !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", StateDbg); end
    Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic test_mvi_program;
    int base;
    load_word(5'd0, 9'o100);
    load_word(5'd1, 9'd5);
    load_word(5'd2, 9'o010);
    base = run_cnt;
    do_start(6'd3);
    vectors++; if (StateDbg !== 3'd1) begin miscompares++; $display("FAIL mvi_waitrdy: got %0d want 1", StateDbg); end
    vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL mvi_busy: got %b want 1", Busy); end
    @(posedge Clock); #1;
    vectors++; if (Run !== 1'b1) begin miscompares++; $display("FAIL mvi_run1: got %b want 1", Run); end
    vectors++; if (DIN !== 9'o100) begin miscompares++; $display("FAIL mvi_din1: got %0o want 100", DIN); end
    @(posedge Clock); #1;
    vectors++; if (Run !== 1'b0) begin miscompares++; $display("FAIL mvi_run_imm: got %b want 0", Run); end
    vectors++; if (DIN !== 9'd5) begin miscompares++; $display("FAIL mvi_imm: got %0d want 5", DIN); end
    wait_run("mvi_second");
    vectors++; if (DIN !== 9'o010) begin miscompares++; $display("FAIL mvi_din2: got %0o want 010", DIN); end
    vectors++; if (Pc !== 5'd2) begin miscompares++; $display("FAIL mvi_pc2: got %0d want 2", Pc); end
    wait_finished("mvi");
    vectors++; if (Error !== 1'b0) begin miscompares++; $display("FAIL mvi_error: got %b want 0", Error); end
    vectors++; if (DIN !== 9'o010) begin miscompares++; $display("FAIL mvi_din_hold: got %0o want 010", DIN); end
    vectors++; if (Pc !== 5'd3) begin miscompares++; $display("FAIL mvi_pc_end: got %0d want 3", Pc); end
    vectors++; if (regs[1] !== 9'd5) begin miscompares++; $display("FAIL mvi_r1: got %0d want 5", regs[1]); end
    vectors++; if (run_cnt - base !== 2) begin miscompares++; $display("FAIL mvi_run_count: got %0d want 2", run_cnt - base); end
  endtask

  task automatic test_hold_ready;
    hold_low = 1'b1;
    do_start(6'd3);
    for (int i = 0; i < 8; i++) begin
      @(posedge Clock); #1;
      vectors++; if (Run !== 1'b0) begin miscompares++; $display("FAIL hold_run[%0d]: got %b want 0", i, Run); end
      vectors++; if (StateDbg !== 3'd1) begin miscompares++; $display("FAIL hold_state[%0d]: got %0d want 1", i, StateDbg); end
    end
    vectors++; if (DIN !== 9'o100) begin miscompares++; $display("FAIL hold_din: got %0o want 100", DIN); end
    hold_low = 1'b0;
    @(posedge Clock); #1;
    vectors++; if (Run !== 1'b1) begin miscompares++; $display("FAIL hold_release_run: got %b want 1", Run); end
    wait_finished("hold");
  endtask

  task automatic test_load_while_busy;
    do_start(6'd3);
    @(posedge Clock); #1;
    load_word(5'd0, 9'o201);
    load_word(5'd2, 9'o000);
    wait_finished("busyload_first");
    do_start(6'd3);
    @(posedge Clock); #1;
    vectors++; if (DIN !== 9'o100) begin miscompares++; $display("FAIL busyload_w0: got %0o want 100", DIN); end
    @(posedge Clock); #1;
    vectors++; if (DIN !== 9'd5) begin miscompares++; $display("FAIL busyload_w1: got %0d want 5", DIN); end
    wait_run("busyload");
    vectors++; if (DIN !== 9'o010) begin miscompares++; $display("FAIL busyload_w2: got %0o want 010", DIN); end
    wait_finished("busyload_rerun");
    vectors++; if (regs[1] !== 9'd5) begin miscompares++; $display("FAIL busyload_r1: got %0d want 5", regs[1]); end
  endtask

  task automatic test_timeout;
    int base;
    stuck = 1'b1;
    base = run_cnt;
    do_start(6'd3);
    repeat (17) @(posedge Clock);
    #1;
    vectors++; if (StateDbg !== 3'd4) begin miscompares++; $display("FAIL timeout_waitlo: got %0d want 4", StateDbg); end
    vectors++; if (Finished !== 1'b0) begin miscompares++; $display("FAIL timeout_early: got %b want 0", Finished); end
    @(posedge Clock); #1;
    vectors++; if (Finished !== 1'b1) begin miscompares++; $display("FAIL timeout_finished: got %b want 1", Finished); end
    vectors++; if (Error !== 1'b1) begin miscompares++; $display("FAIL timeout_error: got %b want 1", Error); end
    vectors++; if (run_cnt - base !== 1) begin miscompares++; $display("FAIL timeout_runs: got %0d want 1", run_cnt - base); end
    stuck = 1'b0;
    // Restart with a single mvi word: clears Error and exercises a truncated mvi.
    base = run_cnt;
    do_start(6'd1);
    vectors++; if (Error !== 1'b0) begin miscompares++; $display("FAIL restart_error_clear: got %b want 0", Error); end
    wait_finished("trunc");
    vectors++; if (Pc !== 5'd2) begin miscompares++; $display("FAIL trunc_pc: got %0d want 2", Pc); end
    vectors++; if (DIN !== 9'd5) begin miscompares++; $display("FAIL trunc_din: got %0d want 5", DIN); end
    vectors++; if (Error !== 1'b0) begin miscompares++; $display("FAIL trunc_error: got %b want 0", Error); end
    vectors++; if (run_cnt - base !== 1) begin miscompares++; $display("FAIL trunc_runs: got %0d want 1", run_cnt - base); end
  endtask

  task automatic test_zero_length;
    int base;
    base = run_cnt;
    do_start(6'd0);
    vectors++; if (Finished !== 1'b1) begin miscompares++; $display("FAIL zero_finished: got %b want 1", Finished); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy: got %b want 0", Busy); end
    repeat (4) @(posedge Clock);
    #1;
    vectors++; if (run_cnt - base !== 0) begin miscompares++; $display("FAIL zero_runs: got %0d want 0", run_cnt - base); end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    load_word(5'd0, 9'o201);
    load_word(5'd1, 9'o311);
    done_delay = 3;
    do_start(6'd2);
    wait_run("b2b_first");
    for (int i = 0; i < 30; i++) begin
      @(posedge Clock); #1;
      n++;
      if (Run) break;
    end
    vectors++; if (n !== 5) begin miscompares++; $display("FAIL b2b_spacing: got %0d want 5", n); end
    vectors++; if (DIN !== 9'o311) begin miscompares++; $display("FAIL b2b_din: got %0o want 311", DIN); end
    wait_finished("b2b");
    vectors++; if (regs[0] !== 9'd10) begin miscompares++; $display("FAIL b2b_r0: got %0d want 10", regs[0]); end
    vectors++; if (regs[1] !== 9'd0) begin miscompares++; $display("FAIL b2b_r1: got %0d want 0", regs[1]); end
  endtask

  task automatic test_reset_mid;
    logic found = 1'b0;
    done_delay = 8;
    do_start(6'd1);
    for (int i = 0; i < 30; i++) begin
      @(posedge Clock); #1;
      if (StateDbg == 3'd5) begin found = 1'b1; break; end
    end
    vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL rstmid_waithi: state %0d never reached 5", StateDbg); end
    #2 Reset = 1'b1;
    #1;
    vectors++; if (DIN !== 9'd0) begin miscompares++; $display("FAIL rstmid_din: got %0o want 0", DIN); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", Busy); end
    vectors++; if (Finished !== 1'b0) begin miscompares++; $display("FAIL rstmid_finished: got %b want 0", Finished); end
    vectors++; if (StateDbg !== 3'd0) begin miscompares++; $display("FAIL rstmid_state: got %0d want 0", StateDbg); end
    vectors++; if (Run !== 1'b0) begin miscompares++; $display("FAIL rstmid_run: got %b want 0", Run); end
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge Clock); #1;
      vectors++; if (Run !== 1'b0) begin miscompares++; $display("FAIL rstmid_run_after[%0d]: got %b want 0", i, Run); end
    end
    vectors++; if (StateDbg !== 3'd0) begin miscompares++; $display("FAIL rstmid_idle: got %0d want 0", StateDbg); end
  endtask

  initial begin
    test_reset;
    test_mvi_program;
    test_hold_ready;
    test_load_while_busy;
    test_timeout;
    test_zero_length;
    test_back_to_back;
    test_reset_mid;
    vectors++;
    if (run_bad !== 1'b0) begin miscompares++; $display("FAIL run_protocol: got %b want 0", run_bad); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/proc_sequencer.md
# proc_sequencer

Instruction sequencer driving the 9-bit processor's `DIN`/`Run`/`Done` handshake from the initiator side. It holds a small program buffer loaded over a write port. On `Start` it issues each word to the processor. For `mvi`, it also supplies the immediate word in the cycle after the instruction is captured, then waits for the processor's `Done` before moving to the next instruction. It sits between the board-level loader (switches/host) and `proc`, replacing manual stepping of `Run`.

## Interface
- `ADDR_W`, 5: program buffer address width; depth 2**ADDR_W words.
- `DATA_W`, 9: instruction/data word width; fixed to processor bus width.
- `TIMEOUT`, 15: max cycles waited for `ProcDone` to fall and then rise.

- `Clock` in 1: single clock; all state on rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `LoadEn` in 1: write `LoadData` into buffer at `LoadAddr`. Ignored while `Busy`.
- `LoadAddr` in ADDR_W: buffer write address.
- `LoadData` in DATA_W: buffer write data.
- `Start` in 1: begin execution at address 0. Sampled only in IDLE/FINISH.
- `Length` in ADDR_W+1: number of buffer words to execute. Captured on `Start`. 0 means finish immediately.
- `ProcDone` in 1: processor `Done`. High = processor idle and ready.
- `DIN` out DATA_W: word presented to processor `DIN`.
- `Run` out 1: one-cycle issue strobe to processor.
- `Pc` out ADDR_W: address of the current instruction.
- `Busy` out 1: high from the `Start`-accepted cycle until FINISH.
- `Finished` out 1: high in FINISH state.
- `Error` out 1: sticky handshake-timeout flag, cleared by `Start` or `Reset`.

## Operation
- Opcode is `word[8:6]`: `mv`=000, `mvi`=001, `add`=010, `sub`=011. `mvi` occupies two words: the instruction, then the immediate.
- Buffer is a register array with combinational read. It is not reset.
- State machine:
  - **IDLE**: `Start` → captures `Length`, `Pc`=0, `Error`=0, then WAITRDY. If `Length`=0, goes to FINISH instead.
  - **WAITRDY**: drives `DIN`=mem[Pc]. When `ProcDone`=1 → ISSUE.
  - **ISSUE**: `Run`=1 for exactly this cycle, `DIN`=mem[Pc]. If opcode=`mvi` → IMM, else → WAITLO.
  - **IMM**: `DIN`=mem[Pc+1], `Run`=0 → WAITLO.
  - **WAITLO**: waits for `ProcDone`=0 → WAITHI.
  - **WAITHI**: waits for `ProcDone`=1. Then advances `Pc` by 2 for `mvi`, otherwise by 1. If new `Pc` ≥ `Length` → FINISH, else → ISSUE. `ProcDone` is already high, so WAITRDY is skipped.
  - **FINISH**: `Finished`=1. `Start` restarts as in IDLE. `LoadEn` is accepted.
- Timeout: a counter clears on entry to WAITLO and on entry to WAITHI. If it reaches `TIMEOUT` in either state, set `Error` and go to FINISH.
- Truncated `mvi`: if an `mvi` is the last word (Pc+1 ≥ `Length`), it still issues. The immediate is taken from mem[Pc+1] with the address wrapping modulo depth, and execution then finishes.
- `Pc` arithmetic is ADDR_W+1 wide internally for the `Length` compare; the `Pc` output is truncated.
- `DIN` holds its last driven value in WAITLO/WAITHI/FINISH.
- `Start` while `Busy` is ignored.
- Reset mid-instruction returns to IDLE at once. The processor is not reset by this block.

## Timing
- Reset values: `DIN`=0, `Run`=0, `Pc`=0, `Busy`=0, `Finished`=0, `Error`=0, state IDLE.
- `Start` at edge N (with `ProcDone`=1): WAITRDY during cycle N+1, `Run`=1 during N+2.
- Issue-to-issue for a non-`mvi` instruction with a processor that drops `Done` 1 cycle after capture and raises it k cycles later: k+2 cycles.
- For `mvi`, the immediate is on `DIN` in the cycle immediately after the `Run` cycle, which is the processor's T1.
- `Run` is never high on two consecutive cycles.
- `Run` is never high while `ProcDone`=0 is sampled in WAITRDY.

## Structure
- Shared package `proc_pkg` holds:
  - opcode constants (`OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`);
  - word width 9;
  - sequencer state encoding.
  The processor uses the same opcode constants.
- One natural sub-module: `prog_buffer`, a register-array memory with synchronous write and combinational read. The FSM, counters and timeout stay in `proc_sequencer`.

## Test plan
- Load [`mvi R0`=9'o100, 9'd5, `mv R1,R0`=9'o010], `Length`=3, `Start` with a responsive processor model. Expect:
  - `Run` pulses with `DIN`=9'o100, then 9'd5 on the next cycle;
  - a second `Run` with `DIN`=9'o010;
  - `Finished`=1, `Error`=0, and model R1=5.
- Hold `ProcDone`=0 after `Start`. Expect WAITRDY held and `Run` never asserted. Release `ProcDone`; `Run` pulses the next cycle.
- Model never drops `Done` after `Run`. Expect `Error`=1 after `TIMEOUT` cycles and `Finished`=1. A subsequent `Start` clears `Error`.
- `Length`=0, `Start`. Expect `Finished`=1 one cycle later with no `Run` pulse.
- Assert `Reset` during WAITHI of an `add`. Expect all outputs at reset values asynchronously, and `Run`=0 thereafter.
- `LoadEn` while `Busy`. Expect the buffer unchanged, verified by re-executing the program.
